band_scale_seq: RTL and testbench

// - Multi-channel, time-multiplexed successor to the single-band scaler in the equalizer datapath.
// - Accepts one frame: NUM_CH signed audio samples plus NUM_CH potentiometer readings.
// - Applies a squared-pot gain of 0..~4x to each band, saturating, through one shared multiplier.
// - Sits between the band FIR filters and the band summer; optional per-band gain slew suppresses zipper noise.

---
 rtl/band_scale_pkg.sv | 51 +++++
 rtl/band_scale_mac.sv | 23 ++
 rtl/band_scale_seq.sv | 171 +++++++++++++++++
 tb/tb_band_scale_seq.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/band_scale_pkg.sv
// Shared types, widths and arithmetic helpers for the band scaler.
// Optional feature macro: GAIN_RAMP_EN (per-band gain slew, used in band_scale_seq).
package band_scale_pkg;

  localparam int DATA_W = 16;
  localparam int POT_W  = 12;
  localparam int PROD_W = DATA_W + POT_W + 1;
  localparam int SHIFT  = POT_W - 2;

  localparam logic signed [PROD_W-1:0] SAT_MAX =
    $signed({{(PROD_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}});
  localparam logic signed [PROD_W-1:0] SAT_MIN =
    $signed({{(PROD_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}});

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic              sat;
    logic [DATA_W-1:0] val;
  } mac_res_t;

  // Squared pot law: (pot*pot) >> POT_W, so mid-scale 0x800 gives unity (1024).
  function automatic logic [POT_W-1:0] sq_gain(input logic [POT_W-1:0] pot);
    logic [2*POT_W-1:0] sq;
    sq = {{POT_W{1'b0}}, pot} * {{POT_W{1'b0}}, pot};
    return sq[2*POT_W-1:POT_W];
  endfunction

  // Floor-shift the product back to sample scale and clip to the sample range.
  function automatic mac_res_t sat_shift(input logic signed [PROD_W-1:0] product);
    logic signed [PROD_W-1:0] sh;
    mac_res_t res;
    sh = product >>> SHIFT;
    if (sh > SAT_MAX) begin
      res.sat = 1'b1;
      res.val = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (sh < SAT_MIN) begin
      res.sat = 1'b1;
      res.val = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      res.sat = 1'b0;
      res.val = sh[DATA_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/band_scale_mac.sv
// One-channel combinational multiply / shift / saturate, shared across bands.
module band_scale_mac
  import band_scale_pkg::*;
(
  input  logic [DATA_W-1:0] sample_i,
  input  logic [POT_W-1:0]  gain_i,
  output logic [DATA_W-1:0] result_o,
  output logic              sat_o
);

  logic signed [PROD_W-1:0] prod_s;
  mac_res_t                 res_s;

  // Signed sample times non-negative gain, then scale back and clip.
  always_comb begin
    prod_s   = $signed({{(POT_W+1){sample_i[DATA_W-1]}}, sample_i}) *
               $signed({{DATA_W{1'b0}}, 1'b0, gain_i});
    res_s    = sat_shift(prod_s);
    result_o = res_s.val;
    sat_o    = res_s.sat;
  end

endmodule

// File: rtl/band_scale_seq.sv
// Time-multiplexed multi-band gain scaler: one frame in, NUM_CH bands
// processed one per cycle through a single MAC, full frame published at once.
// Optional feature macro: GAIN_RAMP_EN (per-band gain registers slewing
// toward the pot target by at most RAMP_STEP per frame).
module band_scale_seq
  import band_scale_pkg::*;
#(
  parameter int NUM_CH    = 5,
  parameter int RAMP_STEP = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_vld,
  output logic                     in_rdy,
  input  logic [NUM_CH*DATA_W-1:0] audio,
  input  logic [NUM_CH*POT_W-1:0]  pot,
  output logic                     out_vld,
  output logic [NUM_CH*DATA_W-1:0] scaled,
  output logic [NUM_CH-1:0]        sat_flag
);

  localparam int CNT_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_CH - 1);

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [NUM_CH*DATA_W-1:0]  audio_q, audio_d;
  logic [NUM_CH*POT_W-1:0]   pot_q, pot_d;
  logic [NUM_CH*DATA_W-1:0]  stage_q, stage_d;
  logic [NUM_CH-1:0]         stage_sat_q, stage_sat_d;
  logic [NUM_CH*DATA_W-1:0]  scaled_q, scaled_d;
  logic [NUM_CH-1:0]         sat_q, sat_d;
  logic                      out_vld_q, out_vld_d;
  logic                      in_rdy_q, in_rdy_d;

  logic [DATA_W-1:0]         sample_s;
  logic [POT_W-1:0]          tgt_s;
  logic [POT_W-1:0]          gain_s;
  logic [DATA_W-1:0]         mac_val_s;
  logic                      mac_sat_s;

`ifdef GAIN_RAMP_EN
  localparam logic [POT_W-1:0] STEP = POT_W'(RAMP_STEP);
  logic [POT_W-1:0] g_q [NUM_CH];
  logic [POT_W-1:0] g_d [NUM_CH];
  logic [POT_W-1:0] g_cur_s;
`endif

  // Select the active channel's sample and derive the gain applied this cycle.
  always_comb begin
    sample_s = audio_q[cnt_q*DATA_W +: DATA_W];
    tgt_s    = sq_gain(pot_q[cnt_q*POT_W +: POT_W]);
`ifdef GAIN_RAMP_EN
    g_cur_s = g_q[cnt_q];
    if (tgt_s > g_cur_s) begin
      if ((tgt_s - g_cur_s) > STEP) begin
        gain_s = g_cur_s + STEP;
      end else begin
        gain_s = tgt_s;
      end
    end else begin
      if ((g_cur_s - tgt_s) > STEP) begin
        gain_s = g_cur_s - STEP;
      end else begin
        gain_s = tgt_s;
      end
    end
`else
    gain_s = tgt_s;
`endif
  end

  band_scale_mac u_mac (
    .sample_i (sample_s),
    .gain_i   (gain_s),
    .result_o (mac_val_s),
    .sat_o    (mac_sat_s)
  );

  // Next-state and datapath update: capture, per-channel compute, publish.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    audio_d     = audio_q;
    pot_d       = pot_q;
    stage_d     = stage_q;
    stage_sat_d = stage_sat_q;
    scaled_d    = scaled_q;
    sat_d       = sat_q;
    out_vld_d   = 1'b0;
`ifdef GAIN_RAMP_EN
    g_d = g_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_vld && in_rdy_q) begin
          audio_d = audio;
          pot_d   = pot;
          cnt_d   = '0;
          state_d = CALC;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        stage_d[cnt_q*DATA_W +: DATA_W] = mac_val_s;
        stage_sat_d[cnt_q]              = mac_sat_s;
`ifdef GAIN_RAMP_EN
        g_d[cnt_q] = gain_s;
`endif
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        scaled_d  = stage_q;
        sat_d     = stage_sat_q;
        out_vld_d = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_rdy_d = (state_d == IDLE);
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      audio_q     <= '0;
      pot_q       <= '0;
      stage_q     <= '0;
      stage_sat_q <= '0;
      scaled_q    <= '0;
      sat_q       <= '0;
      out_vld_q   <= 1'b0;
      in_rdy_q    <= 1'b1;
`ifdef GAIN_RAMP_EN
      for (int i = 0; i < NUM_CH; i++) begin
        g_q[i] <= '0;
      end
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      audio_q     <= audio_d;
      pot_q       <= pot_d;
      stage_q     <= stage_d;
      stage_sat_q <= stage_sat_d;
      scaled_q    <= scaled_d;
      sat_q       <= sat_d;
      out_vld_q   <= out_vld_d;
      in_rdy_q    <= in_rdy_d;
`ifdef GAIN_RAMP_EN
      g_q <= g_d;
`endif
    end
  end

  assign in_rdy   = in_rdy_q;
  assign out_vld  = out_vld_q;
  assign scaled   = scaled_q;
  assign sat_flag = sat_q;

endmodule

// File: tb/tb_band_scale_seq.sv
// Directed, table-driven bench for band_scale_seq (5 bands, 16-bit audio, 12-bit pots).
module tb_band_scale_seq;

  localparam int NUM_CH = 5;
  localparam int AW     = NUM_CH * 16;
  localparam int PW     = NUM_CH * 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_vld;
  logic              in_rdy;
  logic [AW-1:0]     audio;
  logic [PW-1:0]     pot;
  logic              out_vld;
  logic [AW-1:0]     scaled;
  logic [NUM_CH-1:0] sat_flag;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [AW-1:0]     audio;
    logic [PW-1:0]     pot;
    logic [AW-1:0]     exp_scaled;
    logic [NUM_CH-1:0] exp_sat;
  } vec_t;

  band_scale_seq #(.NUM_CH(NUM_CH), .RAMP_STEP(256)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .audio    (audio),
    .pot      (pot),
    .out_vld  (out_vld),
    .scaled   (scaled),
    .sat_flag (sat_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Offer one frame, wait for out_vld; return outputs and accept->out_vld latency.
  task automatic do_frame(input logic [AW-1:0] a, input logic [PW-1:0] p,
                          output logic [AW-1:0] s, output logic [NUM_CH-1:0] f,
                          output int lat, output logic rdy_at_out);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_rdy && w < 20) begin
      @(negedge clk);
      w++;
    end
    in_vld = 1'b1;
    audio  = a;
    pot    = p;
    @(posedge clk);
    #1 in_vld = 1'b0;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_vld) break;
    end
    s          = scaled;
    f          = sat_flag;
    rdy_at_out = in_rdy;
  endtask

  initial begin
    vec_t              vecs [5];
    logic [AW-1:0]     s;
    logic [NUM_CH-1:0] f;
    int                lat;
    logic              r;
    logic [AW-1:0]     expq [$];
    int                n_acc, n_out, last_acc, vld_seen;
    logic [15:0]       v16;
    logic [AW-1:0]     a;

    in_vld = 1'b0;
    audio  = '0;
    pot    = '0;
    rst    = 1'b1;
    #1;
    chk("reset_in_rdy",   {95'd0, in_rdy},   96'd1);
    chk("reset_out_vld",  {95'd0, out_vld},  96'd0);
    chk("reset_scaled",   {16'd0, scaled},   96'd0);
    chk("reset_sat_flag", {91'd0, sat_flag}, 96'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

`ifdef GAIN_RAMP_EN
    // Gains start at zero and slew by 256 per frame toward unity (1024).
    for (int k = 0; k < 5; k++) begin
      logic [15:0] e16;
      e16 = (k < 4) ? 16'((k + 1) * 256) : 16'h0400;
      do_frame({NUM_CH{16'h0400}}, {NUM_CH{12'h800}}, s, f, lat, r);
      chk("ramp_latency", 96'(lat), 96'd6);
      chk("ramp_scaled",  {16'd0, s}, {16'd0, {NUM_CH{e16}}});
      chk("ramp_sat",     {91'd0, f}, 96'd0);
    end
`else
    // Unity gain
    vecs[0].audio      = {NUM_CH{16'h1234}};
    vecs[0].pot        = {NUM_CH{12'h800}};
    vecs[0].exp_scaled = {NUM_CH{16'h1234}};
    vecs[0].exp_sat    = 5'b00000;
    // Max gain 4094/1024: small, +/- saturating, -1 floors to -4, zero
    vecs[1].audio      = {16'h0000, 16'hFFFF, 16'h8000, 16'h4000, 16'h0010};
    vecs[1].pot        = {NUM_CH{12'hFFF}};
    vecs[1].exp_scaled = {16'h0000, 16'hFFFC, 16'h8000, 16'h7FFF, 16'h003F};
    vecs[1].exp_sat    = 5'b00110;
    // Zero gain
    vecs[2].audio      = {NUM_CH{16'hFFFF}};
    vecs[2].pot        = {NUM_CH{12'h000}};
    vecs[2].exp_scaled = {AW{1'b0}};
    vecs[2].exp_sat    = 5'b00000;
    // Different pot per band: unity, max, quarter, ~0.5x*4 (clips), pot=1 -> gain 0
    vecs[3].audio      = {16'h7FFF, 16'h7FFF, 16'h8000, 16'h1000, 16'h0100};
    vecs[3].pot        = {12'h001, 12'hB50, 12'h400, 12'hFFF, 12'h800};
    vecs[3].exp_scaled = {16'h0000, 16'h7FFF, 16'hE000, 16'h3FF8, 16'h0100};
    vecs[3].exp_sat    = 5'b01000;
    // Quarter gain: floor rounding of small negatives and positives
    vecs[4].audio      = {16'h8000, 16'h7FFF, 16'hFFFC, 16'h0003, 16'hFFFF};
    vecs[4].pot        = {NUM_CH{12'h400}};
    vecs[4].exp_scaled = {16'hE000, 16'h1FFF, 16'hFFFF, 16'h0000, 16'hFFFF};
    vecs[4].exp_sat    = 5'b00000;

    for (int k = 0; k < 5; k++) begin
      do_frame(vecs[k].audio, vecs[k].pot, s, f, lat, r);
      chk("latency",       96'(lat), 96'd6);
      chk("scaled",        {16'd0, s}, {16'd0, vecs[k].exp_scaled});
      chk("sat_flag",      {91'd0, f}, {91'd0, vecs[k].exp_sat});
      chk("rdy_with_vld",  {95'd0, r}, 96'd1);
      @(posedge clk);
      #1;
      chk("out_vld_pulse", {95'd0, out_vld}, 96'd0);
      chk("scaled_held",   {16'd0, scaled}, {16'd0, vecs[k].exp_scaled});
    end

    // Busy: in_vld held for 20 cycles with inputs changing every cycle.
    n_acc = 0;
    n_out = 0;
    last_acc = -1;
    for (int c = 0; c < 36; c++) begin
      @(negedge clk);
      if (out_vld) begin
        n_out++;
        if (expq.size() > 0) begin
          chk("busy_scaled", {16'd0, scaled}, {16'd0, expq.pop_front()});
        end else begin
          chk("busy_extra_out", 96'd1, 96'd0);
        end
      end
      if (c < 20) begin
        v16 = 16'(c * 16'h0111 + 16'h0021);
        for (int i = 0; i < NUM_CH; i++) a[i*16 +: 16] = v16 ^ 16'(i * 16'h1001);
        in_vld = 1'b1;
        audio  = a;
        pot    = {NUM_CH{12'h800}};
        if (in_rdy) begin
          if (last_acc >= 0) chk("busy_spacing", 96'(c - last_acc), 96'd7);
          last_acc = c;
          n_acc++;
          expq.push_back(a);
        end
      end else begin
        in_vld = 1'b0;
      end
    end
    chk("busy_accepts", 96'(n_acc), 96'd3);
    chk("busy_outputs", 96'(n_out), 96'd3);
`endif

    // Reset two cycles into a frame: abort, outputs cleared immediately.
    @(negedge clk);
    in_vld = 1'b1;
    audio  = {NUM_CH{16'h5555}};
    pot    = {NUM_CH{12'h800}};
    @(posedge clk);
    #1 in_vld = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_in_rdy",  {95'd0, in_rdy},   96'd1);
    chk("midrst_out_vld", {95'd0, out_vld},  96'd0);
    chk("midrst_scaled",  {16'd0, scaled},   96'd0);
    chk("midrst_sat",     {91'd0, sat_flag}, 96'd0);
    @(negedge clk);
    rst = 1'b0;
    vld_seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (out_vld) vld_seen++;
    end
    chk("midrst_no_out_vld", 96'(vld_seen), 96'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
